// File: rtl/branch_update_ctrl.sv
// Branch-resolution update sequencer: FIFO-buffers resolved branches and issues one
// predictor/BTB update per cycle with freeze/flush control. Optional statistics: BRU_STATS_EN.
module branch_update_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_WIDTH-1:0]        in_pc,
  input  logic [DATA_WIDTH-1:0]        in_target,
  input  logic                         in_taken,
  input  logic                         in_is_cond,
  input  logic                         in_mispredict,
  input  logic                         freeze,
  input  logic                         flush,
  output logic                         update_predictor,
  output logic                         update_btb,
  output logic                         actually_taken,
  output logic [DATA_WIDTH-1:0]        resolved_pc,
  output logic [DATA_WIDTH-1:0]        resolved_pc_target,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [CNT_WIDTH-1:0]         stat_branches,
  output logic [CNT_WIDTH-1:0]         stat_mispredicts
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] target;
    logic                  taken;
    logic                  is_cond;
    logic                  mispredict;
  } entry_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  entry_t                mem_q [DEPTH];
  entry_t                head_s;
  entry_t                wr_entry_s;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  state_t                state_q, state_d;
  logic                  push_s;
  logic                  pop_s;

  logic                  upd_pred_q;
  logic                  upd_btb_q;
  logic                  taken_q;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] target_q;

  // Ready depends only on registered occupancy, never on a same-cycle pop.
  assign in_ready   = (count_q < CW'(DEPTH));
  assign head_s     = mem_q[rd_ptr_q];
  assign wr_entry_s = '{pc: in_pc, target: in_target, taken: in_taken,
                        is_cond: in_is_cond, mispredict: in_mispredict};

  // Push/pop qualification and next pointer/occupancy values
  always_comb begin
    push_s   = in_valid && in_ready && !flush;
    pop_s    = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    case (state_q)
      S_ISSUE: pop_s = !freeze && !flush;
      S_IDLE:  pop_s = 1'b0;
      S_HOLD:  pop_s = 1'b0;
      default: pop_s = 1'b0;
    endcase
    if (flush) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + CW'(push_s) - CW'(pop_s);
    end
  end

  // Next state from next occupancy and the current freeze level
  always_comb begin
    state_d = state_q;
    if (flush || (count_d == {CW{1'b0}})) begin
      state_d = S_IDLE;
    end else if (freeze) begin
      state_d = S_HOLD;
    end else begin
      state_d = S_ISSUE;
    end
  end

  // State, pointers, occupancy and registered update outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= {PW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      count_q    <= {CW{1'b0}};
      upd_pred_q <= 1'b0;
      upd_btb_q  <= 1'b0;
      taken_q    <= 1'b0;
      pc_q       <= {DATA_WIDTH{1'b0}};
      target_q   <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      upd_pred_q <= pop_s && head_s.is_cond;
      upd_btb_q  <= pop_s && head_s.taken;
      if (pop_s) begin
        taken_q  <= head_s.taken;
        pc_q     <= head_s.pc;
        target_q <= head_s.target;
      end
    end
  end

  // Entry storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (!rst && push_s) begin
      mem_q[wr_ptr_q] <= wr_entry_s;
    end
  end

  assign update_predictor   = upd_pred_q;
  assign update_btb         = upd_btb_q;
  assign actually_taken     = taken_q;
  assign resolved_pc        = pc_q;
  assign resolved_pc_target = target_q;
  assign busy               = (count_q != {CW{1'b0}});
  assign count              = count_q;

`ifdef BRU_STATS_EN
  logic [CNT_WIDTH-1:0] stat_br_q;
  logic [CNT_WIDTH-1:0] stat_mp_q;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                   input logic en);
    if (en && (v != {CNT_WIDTH{1'b1}})) begin
      return v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      return v;
    end
  endfunction

  // Saturating statistics; survive flush, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_br_q <= {CNT_WIDTH{1'b0}};
      stat_mp_q <= {CNT_WIDTH{1'b0}};
    end else begin
      stat_br_q <= sat_inc(stat_br_q, pop_s);
      stat_mp_q <= sat_inc(stat_mp_q, pop_s && head_s.mispredict);
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;
`else
  logic unused_mispredict_s;

  assign unused_mispredict_s = head_s.mispredict;
  assign stat_branches       = {CNT_WIDTH{1'b0}};
  assign stat_mispredicts    = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_branch_update_ctrl.sv
// Scoreboard bench for branch_update_ctrl: queue-based reference model plus a
// strobe monitor that pops expected updates in order.
module tb_branch_update_ctrl;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CNTW  = 32;
  localparam int CW    = $clog2(DEPTH+1);

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_pc;
  logic [DW-1:0]   in_target;
  logic            in_taken;
  logic            in_is_cond;
  logic            in_mispredict;
  logic            freeze;
  logic            flush;
  logic            update_predictor;
  logic            update_btb;
  logic            actually_taken;
  logic [DW-1:0]   resolved_pc;
  logic [DW-1:0]   resolved_pc_target;
  logic            busy;
  logic [CW-1:0]   count;
  logic [CNTW-1:0] stat_branches;
  logic [CNTW-1:0] stat_mispredicts;

  branch_update_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CNTW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_target(in_target), .in_taken(in_taken),
    .in_is_cond(in_is_cond), .in_mispredict(in_mispredict),
    .freeze(freeze), .flush(flush),
    .update_predictor(update_predictor), .update_btb(update_btb),
    .actually_taken(actually_taken), .resolved_pc(resolved_pc),
    .resolved_pc_target(resolved_pc_target), .busy(busy), .count(count),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] pc;
    logic [DW-1:0] tgt;
    bit            taken;
    bit            cond;
    bit            mis;
  } ent_t;

  ent_t          mq[$];   // entries waiting in the FIFO
  ent_t          sq[$];   // updates expected on the strobes, in order
  bit            issue_m;
  ent_t          last_m;
  bit            exp_pred, exp_btb;
  int            st_br_m, st_mp_m;
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every strobe cycle must correspond to the next expected update
  always @(negedge clk) begin
    if (update_predictor === 1'b1 || update_btb === 1'b1) begin
      if (sq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_unexpected: strobe pc=%0h with empty scoreboard", resolved_pc);
      end else begin
        ent_t e;
        e = sq.pop_front();
        chk("sb_pred", {63'd0, update_predictor}, {63'd0, e.cond});
        chk("sb_btb", {63'd0, update_btb}, {63'd0, e.taken});
        chk("sb_taken", {63'd0, actually_taken}, {63'd0, e.taken});
        chk("sb_pc", {32'd0, resolved_pc}, {32'd0, e.pc});
        chk("sb_tgt", {32'd0, resolved_pc_target}, {32'd0, e.tgt});
      end
    end
  end

  task automatic set_in(input bit v, input logic [DW-1:0] pc, input logic [DW-1:0] tgt,
                        input bit tk, input bit cd, input bit ms);
    in_valid      = v;
    in_pc         = pc;
    in_target     = tgt;
    in_taken      = tk;
    in_is_cond    = cd;
    in_mispredict = ms;
  endtask

  // Advance one clock: update the model from the current inputs, then check outputs
  task automatic step();
    bit   ready_m, pop_m, push_m;
    ent_t e;
    ready_m = (mq.size() < DEPTH);
    if (!rst) chk("in_ready", {63'd0, in_ready}, {63'd0, ready_m});
    pop_m  = !rst && issue_m && !freeze && !flush && (mq.size() > 0);
    push_m = !rst && in_valid && ready_m && !flush;
    exp_pred = 1'b0;
    exp_btb  = 1'b0;
    if (rst) begin
      mq.delete();
      sq.delete();
      issue_m = 1'b0;
      last_m  = '{pc: '0, tgt: '0, taken: 1'b0, cond: 1'b0, mis: 1'b0};
      st_br_m = 0;
      st_mp_m = 0;
    end else begin
      if (pop_m) begin
        e        = mq.pop_front();
        last_m   = e;
        exp_pred = e.cond;
        exp_btb  = e.taken;
        st_br_m++;
        if (e.mis) st_mp_m++;
        if (e.cond || e.taken) sq.push_back(e);
      end
      if (push_m) begin
        e = '{pc: in_pc, tgt: in_target, taken: in_taken, cond: in_is_cond, mis: in_mispredict};
        mq.push_back(e);
      end
      if (flush) mq.delete();
      issue_m = (mq.size() > 0) && !freeze;
    end
    @(posedge clk);
    #1;
    chk("count", {{(64-CW){1'b0}}, count}, 64'(mq.size()));
    chk("busy", {63'd0, busy}, {63'd0, (mq.size() != 0)});
    chk("pred_strobe", {63'd0, update_predictor}, {63'd0, exp_pred});
    chk("btb_strobe", {63'd0, update_btb}, {63'd0, exp_btb});
    chk("taken_out", {63'd0, actually_taken}, {63'd0, last_m.taken});
    chk("pc_out", {32'd0, resolved_pc}, {32'd0, last_m.pc});
    chk("tgt_out", {32'd0, resolved_pc_target}, {32'd0, last_m.tgt});
`ifdef BRU_STATS_EN
    chk("stat_br", {32'd0, stat_branches}, 64'(st_br_m));
    chk("stat_mp", {32'd0, stat_mispredicts}, 64'(st_mp_m));
`else
    chk("stat_br_off", {32'd0, stat_branches}, 64'd0);
    chk("stat_mp_off", {32'd0, stat_mispredicts}, 64'd0);
`endif
  endtask

  initial begin
    rst    = 1'b1;
    freeze = 1'b0;
    flush  = 1'b0;
    issue_m = 1'b0;
    set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    rst = 1'b0;

    // single taken conditional: strobes two edges after the push
    set_in(1'b1, 32'h100, 32'h140, 1'b1, 1'b1, 1'b0);
    step();
    set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    chk("lat_pred", {63'd0, update_predictor}, 64'd1);
    chk("lat_pc", {32'd0, resolved_pc}, 64'h100);
    step();
    chk("lat_oneshot", {62'd0, update_predictor, update_btb}, 64'd0);

    // not-taken conditional then unconditional taken jump
    set_in(1'b1, 32'h200, 32'h240, 1'b0, 1'b1, 1'b1);
    step();
    set_in(1'b1, 32'h300, 32'h80, 1'b1, 1'b0, 1'b0);
    step();
    set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step();

    // freeze while pushing five: only four accepted, then drain in order
    freeze = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 32'h1000 + 32'(i * 16), 32'h2000 + 32'(i), i[0], 1'b1, 1'b0);
      step();
    end
    chk("full_ready", {63'd0, in_ready}, 64'd0);
    chk("full_count", {{(64-CW){1'b0}}, count}, 64'd4);
    set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    freeze = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("drain_busy", {63'd0, busy}, 64'd0);

    // fill three under freeze, then flush with a concurrent push
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 32'h5000 + 32'(i), 32'h6000, 1'b1, 1'b1, 1'b0);
      step();
    end
    flush = 1'b1;
    step();
    flush  = 1'b0;
    freeze = 1'b0;
    set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("flush_count", {{(64-CW){1'b0}}, count}, 64'd0);
    for (int i = 0; i < 4; i++) step();

    // ten back-to-back entries, including a not-taken unconditional one
    for (int i = 0; i < 10; i++) begin
      set_in(1'b1, 32'h7000 + 32'(i * 4), 32'h8000 + 32'(i * 4), (i != 3), (i % 3 != 0), (i < 2));
      step();
      chk("stream_cnt_le2", {63'd0, (count <= CW'(2))}, 64'd1);
    end
    set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step();

    // stats survive flush, then reset mid-operation loses queued entries
    flush = 1'b1;
    step();
    flush  = 1'b0;
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 32'h9000 + 32'(i), 32'h9100, 1'b1, 1'b1, 1'b1);
      step();
    end
    set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    rst    = 1'b0;
    freeze = 1'b0;
    for (int i = 0; i < 3; i++) step();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 9) < 7, $urandom, $urandom, $urandom_range(0, 1) == 1,
             $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
      freeze = ($urandom_range(0, 99) < 15);
      flush  = ($urandom_range(0, 99) < 5);
      step();
    end
    set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    freeze = 1'b0;
    flush  = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("sb_drained", 64'(sq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
